// File: rtl/alu_operand_stage.sv
// Operand select/extend and opcode translation ahead of the 16-bit ALU.
// Registered output with a one-entry skid buffer.
module alu_operand_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_rs_val,
  input  logic [15:0] in_rt_val,
  input  logic [7:0]  in_imm,
  input  logic [3:0]  in_dest,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_in1,
  output logic [15:0] out_in2,
  output logic [2:0]  out_control,
  output logic [3:0]  out_dest,
  output logic        err_illegal,
  output logic [15:0] issue_count
);

  typedef struct packed {
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  ctrl;
    logic [3:0]  dest;
  } op_t;

  // encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  op_t         main_q, main_d;
  op_t         skid_q, skid_d;
  op_t         dec;
  logic        legal;
  logic        rdy_q;
  logic        err_q;
  logic [15:0] cnt_q;
  logic        acc;
  logic        acc_ok;
  logic        drain;
  logic [15:0] zimm;
  logic [15:0] simm;
  logic [15:0] shimm;

  assign zimm  = {8'h00, in_imm};
  assign simm  = {{8{in_imm[7]}}, in_imm};
  assign shimm = {12'h000, in_imm[3:0]};

  always_comb begin
    dec.in1  = in_rs_val;
    dec.in2  = in_rt_val;
    dec.ctrl = 3'd0;
    dec.dest = in_dest;
    legal    = 1'b1;
    unique case (in_op)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6: dec.ctrl = in_op[2:0];
      4'd7: begin
        dec.ctrl = 3'd0;
        dec.in2  = zimm;
      end
      4'd8: begin
        dec.ctrl = 3'd1;
        dec.in2  = zimm;
      end
      4'd9: begin
        dec.ctrl = 3'd2;
        dec.in2  = simm;
      end
      4'd10: begin
        dec.ctrl = 3'd4;
        dec.in2  = shimm;
      end
      4'd11: begin
        dec.ctrl = 3'd5;
        dec.in2  = shimm;
      end
      4'd12: begin
        dec.ctrl = 3'd6;
        dec.in2  = simm;
      end
      default: legal = 1'b0;
    endcase
  end

  // rdy_q holds off acceptance until the first edge after reset release
  assign in_ready  = rdy_q & ~state_q[0];
  assign out_valid = state_q[1];
  assign acc       = in_valid & in_ready;
  assign acc_ok    = acc & legal;
  assign drain     = state_q[1] & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc_ok) begin
          main_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc_ok && drain) begin
          main_d = dec;
        end else if (acc_ok) begin
          skid_d  = dec;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= 1'b1;
      err_q   <= acc & ~legal;
      if (drain) cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign out_in1     = main_q.in1;
  assign out_in2     = main_q.in2;
  assign out_control = main_q.ctrl;
  assign out_dest    = main_q.dest;
  assign err_illegal = err_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage.
// Inputs change #1 after posedge; outputs are checked in the same window.
module tb_alu_operand_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_rs_val;
  logic [15:0] in_rt_val;
  logic [7:0]  in_imm;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_in1;
  logic [15:0] out_in2;
  logic [2:0]  out_control;
  logic [3:0]  out_dest;
  logic        err_illegal;
  logic [15:0] issue_count;

  int checks;
  int failures;

  alu_operand_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .in_imm      (in_imm),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_in1     (out_in1),
    .out_in2     (out_in2),
    .out_control (out_control),
    .out_dest    (out_dest),
    .err_illegal (err_illegal),
    .issue_count (issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] rs,
                       input logic [15:0] rt, input logic [7:0] imm,
                       input logic [3:0] dst);
    in_valid  = 1'b1;
    in_op     = op;
    in_rs_val = rs;
    in_rt_val = rt;
    in_imm    = imm;
    in_dest   = dst;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_op = 4'd0; in_rs_val = 16'h0;
    in_rt_val = 16'h0; in_imm = 8'h0; in_dest = 4'h0;
    out_ready = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || err_illegal !== 1'b0 || issue_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_ctl: valid=%b err=%b cnt=%h want 0 0 0000",
               out_valid, err_illegal, issue_count);
    end
    checks++;
    if (out_in1 !== 16'h0 || out_in2 !== 16'h0 || out_control !== 3'd0 ||
        out_dest !== 4'h0) begin
      failures++;
      $display("FAIL reset_data: in1=%h in2=%h ctl=%0d dst=%h want zeros",
               out_in1, out_in2, out_control, out_dest);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_inready: got %b want 0", in_ready);
    end
    #3 reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(4'd9, 16'h0010, 16'h1234, 8'hFE, 4'h5);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_in1 !== 16'h0010 || out_in2 !== 16'hFFFE ||
        out_control !== 3'd2 || out_dest !== 4'h5) begin
      failures++;
      $display("FAIL addi: v=%b in1=%h in2=%h ctl=%0d dst=%h want 1 0010 fffe 2 5",
               out_valid, out_in1, out_in2, out_control, out_dest);
    end
    step();
    checks++;
    if (issue_count !== 16'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL addi_count: cnt=%h v=%b want 0001 0", issue_count, out_valid);
    end
  endtask

  task automatic test_imm_forms();
    drive(4'd7, 16'hAAAA, 16'h1111, 8'h80, 4'h1);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_in2 !== 16'h0080 || out_control !== 3'd0 || out_in1 !== 16'hAAAA) begin
      failures++;
      $display("FAIL andi: in1=%h in2=%h ctl=%0d want aaaa 0080 0",
               out_in1, out_in2, out_control);
    end
    step();
    drive(4'd10, 16'h0001, 16'h2222, 8'hF3, 4'h2);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_in2 !== 16'h0003 || out_control !== 3'd4) begin
      failures++;
      $display("FAIL slli: in2=%h ctl=%0d want 0003 4", out_in2, out_control);
    end
    step();
    drive(4'd3, 16'h0005, 16'h0009, 8'h77, 4'h3);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_in1 !== 16'h0005 || out_in2 !== 16'h0009 || out_control !== 3'd3 ||
        out_dest !== 4'h3) begin
      failures++;
      $display("FAIL sub: in1=%h in2=%h ctl=%0d dst=%h want 0005 0009 3 3",
               out_in1, out_in2, out_control, out_dest);
    end
    step();
    drive(4'd12, 16'h0007, 16'h3333, 8'h80, 4'h4);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_in2 !== 16'hFF80 || out_control !== 3'd6) begin
      failures++;
      $display("FAIL slti: in2=%h ctl=%0d want ff80 6", out_in2, out_control);
    end
    step();
    checks++;
    if (issue_count !== 16'd5) begin
      failures++;
      $display("FAIL imm_count: cnt=%h want 0005", issue_count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(4'd2, 16'h0A01, 16'h0B01, 8'h00, 4'h1);
    step();
    drive(4'd2, 16'h0A02, 16'h0B02, 8'h00, 4'h2);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_dest !== 4'h1) begin
      failures++;
      $display("FAIL b2b_a: rdy=%b v=%b dst=%h want 1 1 1", in_ready, out_valid, out_dest);
    end
    step();
    drive(4'd2, 16'h0A03, 16'h0B03, 8'h00, 4'h3);
    checks++;
    if (in_ready !== 1'b0 || out_dest !== 4'h1 || out_in1 !== 16'h0A01) begin
      failures++;
      $display("FAIL b2b_full: rdy=%b dst=%h in1=%h want 0 1 0a01",
               in_ready, out_dest, out_in1);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_dest !== 4'h1 || out_in2 !== 16'h0B01) begin
      failures++;
      $display("FAIL b2b_hold: rdy=%b dst=%h in2=%h want 0 1 0b01",
               in_ready, out_dest, out_in2);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 4'h2 || out_in1 !== 16'h0A02 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_b: v=%b dst=%h in1=%h rdy=%b want 1 2 0a02 1",
               out_valid, out_dest, out_in1, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 4'h3 || out_in1 !== 16'h0A03) begin
      failures++;
      $display("FAIL b2b_c: v=%b dst=%h in1=%h want 1 3 0a03",
               out_valid, out_dest, out_in1);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || issue_count !== 16'd8) begin
      failures++;
      $display("FAIL b2b_count: v=%b cnt=%h want 0 0008", out_valid, issue_count);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'd14, 16'hDEAD, 16'hBEEF, 8'h12, 4'h6);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ill_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ill_pulse: err=%b v=%b want 1 0", err_illegal, out_valid);
    end
    step();
    checks++;
    if (err_illegal !== 1'b0 || out_valid !== 1'b0 || issue_count !== 16'd8) begin
      failures++;
      $display("FAIL ill_after: err=%b v=%b cnt=%h want 0 0 0008",
               err_illegal, out_valid, issue_count);
    end
    drive(4'd0, 16'h00F0, 16'h0F0F, 8'h00, 4'h7);
    step();
    drive(4'd13, 16'h1111, 16'h2222, 8'h33, 4'h8);
    step();
    in_valid = 1'b0;
    checks++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0 || issue_count !== 16'd9) begin
      failures++;
      $display("FAIL ill_drain: err=%b v=%b cnt=%h want 1 0 0009",
               err_illegal, out_valid, issue_count);
    end
    step();
    checks++;
    if (err_illegal !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ill_drain_after: err=%b v=%b want 0 0", err_illegal, out_valid);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(4'd1, 16'h0101, 16'h0202, 8'h00, 4'h9);
    step();
    drive(4'd1, 16'h0303, 16'h0404, 8'h00, 4'hA);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_full: v=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || issue_count !== 16'h0 || out_in1 !== 16'h0) begin
      failures++;
      $display("FAIL async_reset: v=%b cnt=%h in1=%h want 0 0000 0000",
               out_valid, issue_count, out_in1);
    end
    #2 reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || issue_count !== 16'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: rdy=%b cnt=%h v=%b want 1 0000 0",
               in_ready, issue_count, out_valid);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL skid_flushed: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive(4'd2, 16'h0001, 16'h0001, 8'h00, 4'h0);
    repeat (65536) step();
    in_valid = 1'b0;
    checks++;
    if (issue_count !== 16'hFFFF || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pre: cnt=%h v=%b want ffff 1", issue_count, out_valid);
    end
    step();
    checks++;
    if (issue_count !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap: cnt=%h v=%b want 0000 0", issue_count, out_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_addi();
    test_imm_forms();
    test_back_to_back();
    test_illegal();
    test_reset_full();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
